// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared ALU types and constants: converter FSM state
//                encoding and the default datapath width.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

    localparam int ALU_WIDTH = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/serial_negate_cell.sv
`default_nettype none
// ============================================================================
//  Module      : serial_negate_cell
//  Description : One-bit serial two's-complement negation cell. Bits are
//                copied until the first '1' has passed, then inverted.
//                The "first one seen" flag is the only state.
//  Revision    : 1.0  initial release
// ============================================================================
module serial_negate_cell (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    input  logic negate,
    input  logic b,
    output logic mag_bit,
    output logic seen_one
);

    logic seen_one_q;
    logic seen_one_d;

    // Next value of the flag: clear wins, otherwise accumulate processed ones.
    always_comb begin
        seen_one_d = seen_one_q;
        if (clear) begin
            seen_one_d = 1'b0;
        end else if (en) begin
            seen_one_d = seen_one_q | b;
        end
    end

    // Flag register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            seen_one_q <= 1'b0;
        end else begin
            seen_one_q <= seen_one_d;
        end
    end

    // Invert only once a '1' has already passed and negation is requested.
    assign mag_bit  = b ^ (negate & seen_one_q);
    assign seen_one = seen_one_q;

endmodule : serial_negate_cell
`default_nettype wire

// File: rtl/serial_twos_to_signmag.sv
`default_nettype none
// ============================================================================
//  Module      : serial_twos_to_signmag
//  Description : Bit-serial two's-complement to sign-magnitude converter.
//                One bit per clock, LSB first; the magnitude is built by
//                shifting result bits in from the MSB side. Valid/ready on
//                both sides; input and output phases never overlap.
//  Revision    : 1.0  initial release
// ============================================================================
module serial_twos_to_signmag
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_sign,
    output logic [WIDTH-1:0] out_mag,
    output logic             out_ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    // Counter is sized from WIDTH and is not meant to be overridden.
    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [CNT_W-1:0] c_LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] c_MAG_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [WIDTH-1:0]   mag_q,   mag_d;
    logic               sign_q,  sign_d;
    logic               ovf_q,   ovf_d;

    logic               w_cell_clear;
    logic               w_cell_en;
    logic               w_mag_bit;
    logic               w_seen_one;

    serial_negate_cell u_cell (
        .clk      (clk),
        .reset    (reset),
        .clear    (w_cell_clear),
        .en       (w_cell_en),
        .negate   (sign_q),
        .b        (shift_q[0]),
        .mag_bit  (w_mag_bit),
        .seen_one (w_seen_one)
    );

    // FSM state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: counter, operand shifter, sign, magnitude, overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            shift_q <= '0;
            mag_q   <= '0;
            sign_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            mag_q   <= mag_d;
            sign_q  <= sign_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state and datapath control. All results hold outside SHIFT, which
    // keeps the outputs stable while the consumer applies backpressure.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        mag_d        = mag_q;
        sign_d       = sign_q;
        ovf_d        = ovf_q;
        w_cell_clear = 1'b0;
        w_cell_en    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    shift_d      = in_data;
                    sign_d       = in_data[WIDTH-1];
                    cnt_d        = '0;
                    w_cell_clear = 1'b1;
                    state_d      = S_SHIFT;
                end
            end

            S_SHIFT: begin
                w_cell_en = 1'b1;
                shift_d   = shift_q >> 1;
                mag_d     = {w_mag_bit, mag_q[WIDTH-1:1]};
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == c_LAST_BIT) begin
                    // Only the most negative input maps to a magnitude that
                    // needs the full WIDTH bits.
                    ovf_d   = sign_q & (mag_d == c_MAG_MIN);
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign out_sign  = sign_q;
    assign out_mag   = mag_q;
    assign out_ovf   = ovf_q;

    // The seen-one flag is exported for future reuse; nothing here needs it.
    logic w_unused;
    assign w_unused = w_seen_one;

endmodule : serial_twos_to_signmag
`default_nettype wire

// File: tb/tb_serial_twos_to_signmag.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_twos_to_signmag
//  Description : Scoreboard bench for the serial sign-magnitude converter.
//                Stimulus pushes expected results; a monitor pops and compares
//                on every output handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_serial_twos_to_signmag;

    localparam int WIDTH = 16;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             out_sign;
    logic [WIDTH-1:0] out_mag;
    logic             out_ovf;
    logic             out_valid;
    logic             out_ready;

    serial_twos_to_signmag #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_sign  (out_sign),
        .out_mag   (out_mag),
        .out_ovf   (out_ovf),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected result packed as {sign, mag, ovf}.
    logic [17:0] sb_q[$];
    int          pass_cnt;
    int          tot_cnt;
    int          issued;
    int          received;
    logic        stream_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [17:0] model(input logic [15:0] d);
        logic        s;
        logic [15:0] m;
        s = d[15];
        m = s ? (~d + 16'd1) : d;
        return {s, m, (d == 16'h8000)};
    endfunction

    // Offer a word; push the expected result on the cycle it is accepted.
    task automatic send(input logic [15:0] d, input logic [17:0] exp);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = d;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (in_ready) begin
                sb_q.push_back(exp);
                issued++;
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            tot_cnt++;
            $display("FAIL send_timeout: in_ready stayed %b for word %h", in_ready, d);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Count clocks until out_valid shows up (bounded).
    task automatic wait_valid(output int n);
        n = 0;
        while (n < 100) begin
            @(posedge clk); #1;
            n++;
            if (out_valid) break;
        end
    endtask

    initial begin
        int lat;
        pass_cnt    = 0;
        tot_cnt     = 0;
        issued      = 0;
        received    = 0;
        stream_done = 1'b0;
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_data     = '0;
        out_ready   = 1'b1;

        // Monitor: compare whenever the DUT completes an output handshake.
        fork
            forever begin
                @(negedge clk);
                if (!reset && out_valid && out_ready) begin
                    if (sb_q.size() == 0) begin
                        tot_cnt++;
                        $display("FAIL sb_unexpected: got {sign,mag,ovf}=%h with nothing expected",
                                 {out_sign, out_mag, out_ovf});
                    end else begin
                        check("sb_result", 32'({out_sign, out_mag, out_ovf}), 32'(sb_q.pop_front()));
                        received++;
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sign",  32'(out_sign),  32'd0);
        check("rst_out_mag",   32'(out_mag),   32'd0);
        check("rst_out_ovf",   32'(out_ovf),   32'd0);

        // First word: latency from the handshake edge is WIDTH clocks.
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = 16'h0005;
        @(posedge clk); #1;            // handshake edge
        in_valid = 1'b0;
        sb_q.push_back({1'b1 ^ 1'b1, 16'h0005, 1'b0});
        issued++;
        wait_valid(lat);
        check("latency", 32'(lat), 32'd16);
        check("in_ready_in_done", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        check("in_ready_after", 32'(in_ready), 32'd1);

        // Directed vectors with hand-computed results.
        send(16'hFFFB, {1'b1, 16'h0005, 1'b0});
        send(16'hFF00, {1'b1, 16'h0100, 1'b0});
        send(16'h8000, {1'b1, 16'h8000, 1'b1});
        send(16'h7FFF, {1'b0, 16'h7FFF, 1'b0});
        send(16'h0000, {1'b0, 16'h0000, 1'b0});
        send(16'h0001, {1'b0, 16'h0001, 1'b0});
        send(16'hFFFE, {1'b1, 16'h0002, 1'b0});

        // Backpressure: results hold and new offers are ignored.
        wait_valid(lat);
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(16'hFFFF, {1'b1, 16'h0001, 1'b0});
        wait_valid(lat);
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            in_data  = 16'h1234;
            check("bp_sign",     32'(out_sign),  32'd1);
            check("bp_mag",      32'(out_mag),   32'h0001);
            check("bp_in_ready", 32'(in_ready),  32'd0);
            check("bp_valid",    32'(out_valid), 32'd1);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        send(16'hFFF6, {1'b1, 16'h000A, 1'b0});

        // Reset in the middle of converting 0xFFFB discards the word.
        wait_valid(lat);
        @(posedge clk); #1;
        send(16'hFFFB, {1'b1, 16'h0005, 1'b0});
        repeat (6) @(posedge clk);
        #1 reset = 1'b1;
        issued = issued - sb_q.size();
        sb_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        check("mrst_out_valid", 32'(out_valid), 32'd0);
        check("mrst_in_ready",  32'(in_ready),  32'd1);
        check("mrst_out_sign",  32'(out_sign),  32'd0);
        check("mrst_out_mag",   32'(out_mag),   32'd0);
        check("mrst_out_ovf",   32'(out_ovf),   32'd0);
        send(16'h0003, {1'b0, 16'h0003, 1'b0});

        // Random stream with random downstream readiness.
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    logic [15:0] d;
                    d = 16'($urandom);
                    send(d, model(d));
                end
                stream_done = 1'b1;
            end
            begin
                while (!stream_done) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;

        for (int n = 0; n < 200 && sb_q.size() != 0; n++) @(posedge clk);
        @(negedge clk);
        if (sb_q.size() != 0) begin
            tot_cnt++;
            $display("FAIL sb_drain: %0d results still pending, expected 0", sb_q.size());
        end
        check("word_count", 32'(received), 32'(issued));

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule : tb_serial_twos_to_signmag
`default_nettype wire
